// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake, round-to-nearest-even.
// Optional IEEE special-value decoding is enabled by defining FMUL_PIPE_SPECIAL_EN.
module fmul_pipe #(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y
);

    localparam int M   = MAN_W + 1;
    localparam int PW  = 2 * M;
    localparam int LW  = M / 2;
    localparam int HW  = M - LW;
    localparam int EW2 = EXP_W + 2;
    localparam logic [EW2-1:0] BIAS_E = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] EMAX_E = EW2'((1 << EXP_W) - 1);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic [EXP_W-1:0] ea_in, eb_in;
    logic [MAN_W-1:0] ma_in, mb_in;
    logic             zero_in;
    assign ea_in   = x1[W-2 -: EXP_W];
    assign eb_in   = x2[W-2 -: EXP_W];
    assign ma_in   = x1[MAN_W-1:0];
    assign mb_in   = x2[MAN_W-1:0];
    assign zero_in = (ea_in == '0) | (eb_in == '0);

`ifdef FMUL_PIPE_SPECIAL_EN
    logic a_inf, b_inf, a_nan, b_nan, nan_in, inf_in;
    assign a_inf  = (ea_in == '1) & (ma_in == '0);
    assign b_inf  = (eb_in == '1) & (mb_in == '0);
    assign a_nan  = (ea_in == '1) & (ma_in != '0);
    assign b_nan  = (eb_in == '1) & (mb_in != '0);
    assign nan_in = a_nan | b_nan | (a_inf & (eb_in == '0)) | (b_inf & (ea_in == '0));
    assign inf_in = (a_inf | b_inf) & ~nan_in;
    logic s1_nan, s1_inf, s2_nan, s2_inf;
`endif

    logic             s1_valid, s2_valid;
    logic             s1_sign, s1_zero;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [M-1:0]     s1_ma, s1_mb;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_sign <= x1[W-1] ^ x2[W-1];
            s1_zero <= zero_in;
            s1_ea   <= ea_in;
            s1_eb   <= eb_in;
            s1_ma   <= {1'b1, ma_in};
            s1_mb   <= {1'b1, mb_in};
`ifdef FMUL_PIPE_SPECIAL_EN
            s1_nan  <= nan_in;
            s1_inf  <= inf_in;
`endif
        end
    end

    // Significands are split into high/low halves so each partial product is roughly half width.
    logic [HW-1:0]    a_hi, b_hi;
    logic [LW-1:0]    a_lo, b_lo;
    assign a_hi = s1_ma[M-1:LW];
    assign a_lo = s1_ma[LW-1:0];
    assign b_hi = s1_mb[M-1:LW];
    assign b_lo = s1_mb[LW-1:0];

    logic             s2_sign, s2_zero;
    logic [EW2-1:0]   s2_esum;
    logic [2*LW-1:0]  s2_pp_ll;
    logic [LW+HW-1:0] s2_pp_lh, s2_pp_hl;
    logic [2*HW-1:0]  s2_pp_hh;

    always_ff @(posedge clk) begin
        if (adv && s1_valid) begin
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_esum  <= {2'b00, s1_ea} + {2'b00, s1_eb} - BIAS_E;
            s2_pp_ll <= {{LW{1'b0}}, a_lo} * {{LW{1'b0}}, b_lo};
            s2_pp_lh <= {{HW{1'b0}}, a_lo} * {{LW{1'b0}}, b_hi};
            s2_pp_hl <= {{LW{1'b0}}, a_hi} * {{HW{1'b0}}, b_lo};
            s2_pp_hh <= {{HW{1'b0}}, a_hi} * {{HW{1'b0}}, b_hi};
`ifdef FMUL_PIPE_SPECIAL_EN
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
`endif
        end
    end

    logic [PW-1:0]    prod;
    logic [PW-2:0]    norm;
    logic             guard, sticky, round_up, rovf, under, over;
    logic [MAN_W:0]   man_r;
    logic [EW2-1:0]   e_fin;
    logic [W-1:0]     y_next;

    assign prod = {s2_pp_hh, {(2*LW){1'b0}}}
                + ((PW'(s2_pp_lh) + PW'(s2_pp_hl)) << LW)
                + PW'(s2_pp_ll);

    // Align so the leading one sits just above norm; the product's top bit is the normalise carry.
    assign norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    assign guard    = norm[M-1];
    assign sticky   = |norm[M-2:0];
    assign round_up = guard & (sticky | norm[M]);
    assign man_r    = {1'b0, norm[PW-2:M]} + {{MAN_W{1'b0}}, round_up};
    assign rovf     = man_r[MAN_W];
    assign e_fin    = s2_esum + {{(EW2-1){1'b0}}, prod[PW-1]} + {{(EW2-1){1'b0}}, rovf};
    assign under    = e_fin[EW2-1] | (e_fin == '0);
    assign over     = ~e_fin[EW2-1] & (e_fin >= EMAX_E);

    always_comb begin
        y_next = {s2_sign, e_fin[EXP_W-1:0], man_r[MAN_W-1:0]};
`ifdef FMUL_PIPE_SPECIAL_EN
        if (s2_nan)
            y_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (s2_inf)
            y_next = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
`endif
        if (s2_zero || under)
            y_next = {s2_sign, {(W-1){1'b0}}};
        else if (over)
            y_next = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst)
            y <= '0;
        else if (adv && s2_valid)
            y <= y_next;
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: directed vector table, handshake/reset sequences and a
// randomized scoreboard stream against a plain-arithmetic reference model.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] x1, x2, y;
    logic [15:0] x1h, x2h, yh;
    logic        in_ready_h, out_valid_h;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          sb_en = 1'b0;
    int          rcv_cnt = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] held_y;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] ah;
        logic [15:0] bh;
        bit          half;
        logic [31:0] exp;
    } vec_t;

`ifdef FMUL_PIPE_SPECIAL_EN
    localparam logic [31:0] EXP_INF_ZERO = 32'h7FC00000;
    localparam logic [31:0] EXP_NAN_ONE  = 32'h7FC00000;
`else
    localparam logic [31:0] EXP_INF_ZERO = 32'h00000000;
    localparam logic [31:0] EXP_NAN_ONE  = 32'h7F800000;
`endif

    fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    fmul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
        .x1(x1h), .x2(x2h), .out_valid(out_valid_h), .out_ready(out_ready), .y(yh)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Value-level reference: exact integer product, rounded by quotient/remainder against half an ulp.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int ew, input int mw);
        longint one, bias, emax, mmask, la, lb, ea, eb, ma, mb, s, p, q, rem, half, e;
        int     msb, shift;
`ifdef FMUL_PIPE_SPECIAL_EN
        bit     an, bn, ai, bi;
`endif
        one   = 1;
        bias  = (one << (ew - 1)) - 1;
        emax  = (one << ew) - 1;
        mmask = (one << mw) - 1;
        la    = {32'd0, a};
        lb    = {32'd0, b};
        ma    = la & mmask;
        mb    = lb & mmask;
        ea    = (la >> mw) & emax;
        eb    = (lb >> mw) & emax;
        s     = ((la >> (ew + mw)) ^ (lb >> (ew + mw))) & 1;
`ifdef FMUL_PIPE_SPECIAL_EN
        an = (ea == emax) && (ma != 0);
        bn = (eb == emax) && (mb != 0);
        ai = (ea == emax) && (ma == 0);
        bi = (eb == emax) && (mb == 0);
        if (an || bn || (ai && eb == 0) || (bi && ea == 0))
            return 32'((emax << mw) | (one << (mw - 1)));
        if (ai || bi)
            return 32'((s << (ew + mw)) | (emax << mw));
`endif
        if (ea == 0 || eb == 0)
            return 32'(s << (ew + mw));
        p   = ((one << mw) | ma) * ((one << mw) | mb);
        msb = 0;
        for (int i = 0; i < 62; i++)
            if (p >= (one << i)) msb = i;
        shift = msb - mw;
        q     = p >> shift;
        rem   = p - (q << shift);
        half  = one << (shift - 1);
        if (rem > half || (rem == half && (q % 2) == 1))
            q = q + 1;
        e = ea + eb - bias + msb - 2 * mw;
        if (q == (one << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e <= 0)
            return 32'(s << (ew + mw));
        if (e >= emax)
            return 32'((s << (ew + mw)) | (emax << mw));
        return 32'((s << (ew + mw)) | (e << mw) | (q & mmask));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(3) != 0)
            r[30:23] = 8'($urandom_range(154, 100));
        return r;
    endfunction

    // Scoreboard: predictions enqueue on input transfers, results dequeue on output transfers.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (stall_prev && out_valid)
                checkOutput("y_hold", y, held_y);
            if (in_valid && in_ready)
                exp_q.push_back(ref_mul(x1, x2, 8, 23));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out: got %h, expected no output", y);
                end else begin
                    checkOutput("stream_y", y, exp_q.pop_front());
                    rcv_cnt++;
                end
            end
            if (out_valid && !out_ready) begin
                checkOutput("in_ready_stall", {31'd0, in_ready}, 32'd0);
                stall_prev = 1'b1;
                held_y     = y;
            end else begin
                stall_prev = 1'b0;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        @(posedge clk); #1;
        x1 = v.a; x2 = v.b; x1h = v.ah; x2h = v.bh;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({v.name, "_latency"}, 32'(n), 32'd3);
        if (v.half)
            checkOutput(v.name, {16'd0, yh}, v.exp);
        else
            checkOutput(v.name, y, v.exp);
    endtask

    task automatic streamRandom(input int n, input bit bp_pattern);
        bit done = 1'b0;
        int w = 0;
        rcv_cnt = 0;
        @(posedge clk); #1;
        sb_en = 1'b1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    x1 = rand_fp();
                    x2 = rand_fp();
                    in_valid = 1'b1;
                    waitReady();
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                int c = 0;
                while (!done) begin
                    out_ready = bp_pattern ? !(c >= 4 && c <= 7) : ($urandom_range(3) != 0);
                    @(posedge clk); #1;
                    c++;
                end
                out_ready = 1'b1;
            end
        join
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("stream_count", 32'(rcv_cnt), 32'(n));
        checkOutput("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{"basic_mul",  32'h3FC00000, 32'h40000000, 16'h0, 16'h0, 1'b0, 32'h40400000});
        vecs.push_back('{"neg_mul",    32'hC0000000, 32'h40400000, 16'h0, 16'h0, 1'b0, 32'hC0C00000});
        vecs.push_back('{"one_mul",    32'h3F800000, 32'h3F800000, 16'h0, 16'h0, 1'b0, 32'h3F800000});
        vecs.push_back('{"tie_even",   32'h3F800800, 32'h3F800800, 16'h0, 16'h0, 1'b0, 32'h3F801000});
        vecs.push_back('{"lsb_mul",    32'h3F800001, 32'h3F800001, 16'h0, 16'h0, 1'b0, 32'h3F800002});
        vecs.push_back('{"near_four",  32'h3FFFFFFF, 32'h3FFFFFFF, 16'h0, 16'h0, 1'b0, 32'h407FFFFE});
        vecs.push_back('{"overflow",   32'h7F000000, 32'h7F000000, 16'h0, 16'h0, 1'b0, 32'h7F800000});
        vecs.push_back('{"underflow",  32'h00800000, 32'h00800000, 16'h0, 16'h0, 1'b0, 32'h00000000});
        vecs.push_back('{"neg_zero",   32'h80000000, 32'h3F800000, 16'h0, 16'h0, 1'b0, 32'h80000000});
        vecs.push_back('{"denorm",     32'h00000001, 32'h3F800000, 16'h0, 16'h0, 1'b0, 32'h00000000});
        vecs.push_back('{"inf_x_two",  32'h7F800000, 32'h40000000, 16'h0, 16'h0, 1'b0, 32'h7F800000});
        vecs.push_back('{"inf_x_zero", 32'h7F800000, 32'h00000000, 16'h0, 16'h0, 1'b0, EXP_INF_ZERO});
        vecs.push_back('{"nan_x_one",  32'h7FC00000, 32'h3F800000, 16'h0, 16'h0, 1'b0, EXP_NAN_ONE});
        vecs.push_back('{"half_basic", 32'h0, 32'h0, 16'h3E00, 16'h4000, 1'b1, 32'h00004200});
        vecs.push_back('{"half_neg",   32'h0, 32'h0, 16'hC000, 16'h4200, 1'b1, 32'h0000C600});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x1 = '0; x2 = '0; x1h = '0; x2h = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_y", y, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_in_ready_h", {31'd0, in_ready_h}, 32'd1);
        checkOutput("reset_out_valid_h", {31'd0, out_valid_h}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] backpressure stream");
        streamRandom(8, 1'b1);
        $display("[TB] random stream");
        streamRandom(40, 1'b0);

        // Reset with three operations in flight: all of them must vanish.
        $display("[TB] reset mid-operation");
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x1 = rand_fp();
            x2 = rand_fp();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_y", y, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        applyStimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
Parametrised, fully pipelined floating-point multiplier; next generation of the FPU's 3-cycle multi-state fmul.
- Accepts one operand pair per cycle under a valid/ready handshake with backpressure.
- Generic exponent/mantissa widths; round-to-nearest-even.
- Sits between the issue logic and the FPU writeback arbiter.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa field width (>=4)
(derived W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair present
in_ready  out  1  pipeline can accept this cycle
x1  in  W  operand 1 {sign, exp, man}
x2  in  W  operand 2
out_valid  out  1  y holds a result
out_ready  in  1  consumer accepts y
y  out  W  product

Behaviour:
- Handshake:
  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
  - adv = ~out_valid | out_ready; in_ready = adv (combinational).
- Pipeline:
  - 3 register stages S1 (operand capture/split), S2 (four half-width partial products), S3 (sum, normalise, round -> y).
  - Each stage has a valid bit; all stages advance together when adv=1 and hold everything when adv=0.
  - Latency = 3 cycles from input transfer to out_valid with no stall; throughput 1/cycle; results in order.
- Reset: all stage valid bits = 0, out_valid = 0, y = 0; in_ready = 1 the cycle after reset.
  - Reset mid-operation discards every in-flight result; no output is produced for them.
- y and data registers hold their value while out_valid&~out_ready.
- Arithmetic:
  - Sign: s = s1 ^ s2, for every result including zero.
  - Zero/denormal: exp field 0 treats the operand as zero (flush); result is {s, 0...}.
  - Significands {1,man} are multiplied exactly: 2*(MAN_W+1)-bit product P.
  - Normalise: if P[MSB] then shift right by 1 and carry = 1.
  - Round-to-nearest-even on guard/sticky bits. A rounding overflow to 2.0 renormalises and increments the exponent.
  - Exponent: E = e1 + e2 - BIAS + carry (+1 on round renormalise), computed signed in EXP_W+2 bits.
  - E <= 0: result {s, 0} (underflow flush, no denormals).
  - E >= EMAX: result {s, all-ones, 0} (infinity pattern).
  - Otherwise: {s, E[EXP_W-1:0], rounded man}.

Optional Feature:
Macro FMUL_PIPE_SPECIAL_EN.
- Defined: exponent all-ones inputs decode as IEEE specials (decided in S1, carried as flags to S3):
  - any NaN operand, or inf*zero, gives canonical quiet NaN {0, all-ones, 1, 0...}.
  - inf*finite-nonzero or inf*inf gives {s, all-ones, 0}.
  - zero still wins over finite operands.
- Not defined: exponent all-ones operands are treated as ordinary normal numbers; no NaN is ever produced; the special-flag logic is absent.

Test Plan:
- Basic: 0x3FC00000*0x40000000 (1.5*2.0) -> 0x40400000 exactly 3 cycles after transfer; 0xC0000000*0x40400000 -> 0xC0C00000.
- Tie rounding: 0x3F800800*0x3F800800 -> 0x3F801000 (even; must not be 0x3F801001).
- Over/underflow: 0x7F000000*0x7F000000 -> 0x7F800000; 0x00800000*0x00800000 -> 0x00000000; 0x80000000*0x3F800000 -> 0x80000000.
- Backpressure:
  - Stream 8 random pairs back-to-back, hold out_ready=0 for cycles 4-7.
  - Required: in_ready=0 while the output is stalled; y stable; all 8 results in order, matching the reference model; none lost or duplicated.
- Reset: assert rst for 1 cycle with 3 results in flight -> out_valid=0 the next cycle and no stale output afterwards; the next transfer completes in 3 cycles.
- Special: 0x7F800000*0x00000000 -> 0x7FC00000 with FMUL_PIPE_SPECIAL_EN, 0x00000000 without; also rerun the basic test with EXP_W=5, MAN_W=10: 0x3E00*0x4000 -> 0x4200.
